alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
// - Issuing side of the ALU interface: accepts operation commands, reads operands from an 8x16 register file and drives the alu port set.
// - Port set driven: oe, opcode, in1, in2, carry; samples out and flags back.
// - Writes the result back and keeps the architectural flag register {P,S,Z,O,C}.
// - Sits between the didactic calculator control path and the alu instance.
// PARAMETERS
// - width        16  data path width; must equal alu width
// - flags_width   5  flag vector width; bit order [4]P [3]S [2]Z [1]O [0]C
// - nregs         8  register file entries; addresses are $clog2(nregs) = 3 bits
// PORTS
// - clk        in   1      clock; all state on rising edge
// - rst        in   1      synchronous, active-high reset
// - cmd_valid  in   1      command offered
// - cmd_ready  out  1      command accepted when cmd_valid && cmd_ready
// - cmd_opcode in   4      ALU opcode, passed through unchanged
// - cmd_dst    in   3      destination register
// - cmd_src1   in   3      operand 1 register
// - cmd_src2   in   3      operand 2 register
// - cmd_wb     in   1      1: write result to dst
// - cmd_fl     in   1      1: update flag register
// - rsp_valid  out  1      result available
// - rsp_ready  in   1      consumer takes result
// - rsp_data   out  width  result captured from ALU
// - rsp_flags  out  5      flags captured from ALU
// - ld_en      in   1      direct register load
// - ld_addr    in   3      load address
// - ld_data    in   width  load data
// - dbg_addr   in   3      debug read address
// - dbg_data   out  width  combinational read of regfile[dbg_addr]
// - flags_q    out  5      architectural flag register
// - alu_oe     out  1      ALU output enable
// - alu_opcode out  4      to alu opcode
// - alu_in1    out  width  to alu in1
// - alu_in2    out  width  to alu in2
// - alu_carry  out  1      to alu carry; always equals flags_q[0]
// - alu_out    in   width  from alu out
// - alu_flags  in   5      from alu flags
// BEHAVIOUR
// - Reset (synchronous, rst=1 at a clock edge):
//   - state IDLE; regfile, flags_q, rsp_data, rsp_flags, operand latches all 0.
//   - alu_oe = 0, alu_opcode = 0, rsp_valid = 0.
//   - An in-flight command is dropped: no writeback, no flag update, no response.
// - FSM states: IDLE -> READ -> EXEC -> WB -> RSP -> IDLE.
//   - IDLE: cmd_ready = !ld_en. On accept, latch opcode, dst, src1, src2, wb, fl; go to READ.
//   - READ: op1 <= regfile[src1], op2 <= regfile[src2].
//   - EXEC: alu_oe = 1; alu_in1 = op1, alu_in2 = op2, alu_opcode = latched opcode.
//     Sample alu_out and alu_flags into rsp_data and rsp_flags at the end of the cycle.
//   - WB: if wb, regfile[dst] <= rsp_data; if fl, flags_q <= rsp_flags.
//   - RSP: rsp_valid = 1 and held with stable data until rsp_ready; the handshake cycle returns to IDLE.
// - Latency: accept in cycle 0 -> rsp_valid in cycle 4. Throughput is one command per 5 cycles when rsp_ready = 1.
// - alu_oe is 1 only in EXEC; alu_in1, alu_in2 and alu_opcode hold their last values otherwise.
// - Carry: alu_carry = flags_q sampled before this command's WB, so ADC-style operations chain carries.
// - Register load:
//   - ld_en writes regfile[ld_addr] in any state.
//   - ld_en in IDLE forces cmd_ready = 0, so a load has priority over a new command.
//   - A load to the dst of an in-flight command is overwritten by that command's WB if both fall in the same cycle (WB wins).
// - Operand aliasing: dst == src1 == src2 is legal; operands are read before writeback.
// - Arithmetic: none performed locally; width and overflow semantics belong to the alu.
// STRUCTURE
// - Shared package/include alu_defs: width, flags_width, flag bit indices FL_P/S/Z/O/C, opcode constants OP_*, state encodings.
// - One sub-module: alu_regfile (nregs x width; 1 sync write port, 2 registered read ports, 1 combinational debug read).
// - The sequencer FSM stays in this file.
// TESTING (bench instantiates alu_sequencer + alu, shared opcode constants)
// - Reset test: after rst, cmd_ready = 1, rsp_valid = 0, alu_oe = 0, flags_q = 0, and dbg_data = 0 for all 8 addresses.
// - Load + ADD:
//   - Stimulus: ld R1 = 16'h0003, ld R2 = 16'h0004; ADD dst = R3, wb = 1, fl = 1.
//   - Required: rsp_valid 4 cycles after accept, rsp_data = 16'h0007, R3 = 7, Z = 0, C = 0.
// - Carry chain:
//   - Stimulus: R1 = 16'hFFFF, R2 = 16'h0001; ADD fl = 1, then ADC on R4 = R5 = 0.
//   - Required: C = 1 after the ADD, alu_carry = 1 during the ADC, ADC result = 16'h0001.
// - Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready = 0; release -> IDLE next cycle.
// - Load priority and reset abort:
//   - ld_en together with cmd_valid in IDLE -> command not accepted that cycle.
//   - rst asserted in EXEC -> target register unchanged and no rsp_valid.
// - wb = 0, fl = 1 (compare use): R1 = R2 = 16'h0005, SUB -> R dst unchanged, Z = 1.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issuing sequencer: widths, flag bit positions,
// opcode constants, FSM state encoding and the latched command record.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FLAGS_W  = 5;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
  localparam int unsigned OPC_W    = 4;

  localparam int unsigned FL_P = 4;
  localparam int unsigned FL_S = 3;
  localparam int unsigned FL_Z = 2;
  localparam int unsigned FL_O = 1;
  localparam int unsigned FL_C = 0;

  localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADC = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_SBB = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h6;
  localparam logic [OPC_W-1:0] OP_NOT = 4'h7;
  localparam logic [OPC_W-1:0] OP_SHL = 4'h8;
  localparam logic [OPC_W-1:0] OP_SHR = 4'h9;
  localparam logic [OPC_W-1:0] OP_MOV = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RSP  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              wb;
    logic              fl;
  } cmd_t;

  function automatic cmd_t make_cmd(
    input logic [OPC_W-1:0]  opcode,
    input logic [ADDR_W-1:0] dst,
    input logic [ADDR_W-1:0] src1,
    input logic [ADDR_W-1:0] src2,
    input logic              wb,
    input logic              fl
  );
    cmd_t c;
    c.opcode = opcode;
    c.dst    = dst;
    c.src1   = src1;
    c.src2   = src2;
    c.wb     = wb;
    c.fl     = fl;
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file for the ALU sequencer: writeback port plus direct load port,
// two registered operand read ports and a combinational debug read.
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned NREGS = NUM_REGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [WIDTH-1:0] rdata2_q, rdata2_d;

  // Next-state of every entry; a writeback to the same entry beats a load.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (we && (waddr == AW'(i))) begin
        mem_d[i] = wdata;
      end else if (ld_en && (ld_addr == AW'(i))) begin
        mem_d[i] = ld_data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Operand latches read the pre-write array contents.
  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (rd_en) begin
      rdata1_d = mem_q[raddr1];
      rdata2_d = mem_q[raddr2];
    end else begin
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
    end
  end

  // Array and operand latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      mem_q    <= mem_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issuing side of the ALU interface: reads operands, drives the alu port set,
// captures the result, writes it back and owns the architectural flag register.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned width       = DATA_W,
  parameter int unsigned flags_width = FLAGS_W,
  parameter int unsigned nregs       = NUM_REGS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPC_W-1:0]       cmd_opcode,
  input  logic [ADDR_W-1:0]      cmd_dst,
  input  logic [ADDR_W-1:0]      cmd_src1,
  input  logic [ADDR_W-1:0]      cmd_src2,
  input  logic                   cmd_wb,
  input  logic                   cmd_fl,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [width-1:0]       rsp_data,
  output logic [flags_width-1:0] rsp_flags,
  input  logic                   ld_en,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [width-1:0]       ld_data,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [width-1:0]       dbg_data,
  output logic [flags_width-1:0] flags_q,
  output logic                   alu_oe,
  output logic [OPC_W-1:0]       alu_opcode,
  output logic [width-1:0]       alu_in1,
  output logic [width-1:0]       alu_in2,
  output logic                   alu_carry,
  input  logic [width-1:0]       alu_out,
  input  logic [flags_width-1:0] alu_flags
);

  seq_state_e             state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [width-1:0]       rsp_data_q, rsp_data_d;
  logic [flags_width-1:0] rsp_flags_q, rsp_flags_d;
  logic [flags_width-1:0] flags_d;
  logic [OPC_W-1:0]       alu_opcode_q, alu_opcode_d;
  logic                   alu_oe_q, alu_oe_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   cmd_ready_s;
  logic                   rf_we_s;
  logic                   rf_rd_en_s;

  alu_regfile #(
    .WIDTH (width),
    .NREGS (nregs),
    .AW    (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we_s),
    .waddr    (cmd_q.dst),
    .wdata    (rsp_data_q),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rd_en    (rf_rd_en_s),
    .raddr1   (cmd_q.src1),
    .raddr2   (cmd_q.src2),
    .rdata1   (alu_in1),
    .rdata2   (alu_in2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Sequencer next-state, datapath captures and strobes.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    flags_d      = flags_q;
    alu_opcode_d = alu_opcode_q;
    cmd_ready_s  = 1'b0;
    rf_we_s      = 1'b0;
    rf_rd_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A same-cycle load owns the write port, so hold off new commands.
        cmd_ready_s = ~ld_en;
        if (cmd_valid && !ld_en) begin
          cmd_d   = make_cmd(cmd_opcode, cmd_dst, cmd_src1, cmd_src2, cmd_wb, cmd_fl);
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rf_rd_en_s   = 1'b1;
        alu_opcode_d = cmd_q.opcode;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_flags_d = alu_flags;
        state_d     = ST_WB;
      end
      ST_WB: begin
        rf_we_s = cmd_q.wb;
        if (cmd_q.fl) begin
          flags_d = rsp_flags_q;
        end else begin
          flags_d = flags_q;
        end
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    alu_oe_d    = (state_d == ST_EXEC);
    rsp_valid_d = (state_d == ST_RSP);
  end

  // State, command latch, response and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
      alu_opcode_q <= '0;
      alu_oe_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      flags_q      <= flags_d;
      alu_opcode_q <= alu_opcode_d;
      alu_oe_q     <= alu_oe_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign alu_oe     = alu_oe_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_carry  = flags_q[FL_C];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and a
// transaction-level reference model of registers and flags.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [2:0]  cmd_dst, cmd_src1, cmd_src2;
  logic        cmd_wb, cmd_fl;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [4:0]  flags_q;
  logic        alu_oe;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1, alu_in2;
  logic        alu_carry;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_regs [8];
  logic [4:0]  ref_flags;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_wb(cmd_wb), .cmd_fl(cmd_fl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flags_q(flags_q),
    .alu_oe(alu_oe), .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_carry(alu_carry), .alu_out(alu_out), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {P,S,Z,O,C, result}.
  function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
    logic [16:0] w;
    logic [15:0] r;
    logic c, o;
    w = 17'd0; r = 16'd0; c = 1'b0; o = 1'b0;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                    o = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_ADC: begin w = {1'b0, a} + {1'b0, b} + {16'd0, cin}; r = w[15:0]; c = w[16];
                    o = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                    o = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_SBB: begin w = {1'b0, a} - {1'b0, b} - {16'd0, cin}; r = w[15:0]; c = w[16];
                    o = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin r = {a[14:0], 1'b0}; c = a[15]; end
      OP_SHR: begin r = {1'b0, a[15:1]}; c = a[0]; end
      OP_MOV: r = a;
      default: r = 16'd0;
    endcase
    return {~^r, r[15], (r == 16'd0), o, c, r};
  endfunction

  // The ALU instance: only meaningful while enabled, garbage otherwise.
  logic [20:0] alu_res;
  always_comb begin
    alu_res = alu_model(alu_opcode, alu_in1, alu_in2, alu_carry);
    if (alu_oe) begin
      alu_out   = alu_res[15:0];
      alu_flags = alu_res[20:16];
    end else begin
      alu_out   = 16'hDEAD;
      alu_flags = 5'h15;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    ref_regs[a] = d;
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  logic ex_carry;

  // Issues one command, checks it against the reference model and updates the model.
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] s1,
                         input logic [2:0] s2, input logic wb, input logic fl, input int stall,
                         output logic [15:0] d, output logic [4:0] f);
    logic [20:0] exp;
    logic [15:0] in1_seen, in2_seen;
    logic [3:0]  op_seen;
    int n, oe_cnt, oe_at;
    exp = alu_model(op, ref_regs[s1], ref_regs[s2], ref_flags[FL_C]);
    cmd_opcode = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2; cmd_wb = wb; cmd_fl = fl;
    cmd_valid = 1'b1;
    rsp_ready = (stall == 0);
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    n = 1; oe_cnt = 0; oe_at = 0; in1_seen = 16'd0; in2_seen = 16'd0; op_seen = 4'd0; ex_carry = 1'b0;
    while (!rsp_valid && n < 20) begin
      if (alu_oe) begin
        oe_cnt++; oe_at = n; in1_seen = alu_in1; in2_seen = alu_in2; op_seen = alu_opcode; ex_carry = alu_carry;
      end
      tick(); n++;
    end
    check("latency", 32'(n), 32'd4);
    check("oe_cycle", 32'(oe_at), 32'd2);
    check("oe_pulses", 32'(oe_cnt), 32'd1);
    check("exec_opcode", 32'(op_seen), 32'(op));
    check("exec_in1", 32'(in1_seen), 32'(ref_regs[s1]));
    check("exec_in2", 32'(in2_seen), 32'(ref_regs[s2]));
    check("exec_carry", 32'(ex_carry), 32'(ref_flags[FL_C]));
    check("rsp_data", 32'(rsp_data), 32'(exp[15:0]));
    check("rsp_flags", 32'(rsp_flags), 32'(exp[20:16]));
    d = rsp_data; f = rsp_flags;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(d));
      check("hold_flags", 32'(rsp_flags), 32'(f));
      check("hold_not_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("back_idle", 32'(cmd_ready), 32'd1);
    if (wb) ref_regs[dst] = exp[15:0];
    if (fl) ref_flags = exp[20:16];
    check("flags_q", 32'(flags_q), 32'(ref_flags));
    check_reg("dst_reg", dst, ref_regs[dst]);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [4:0]  f;
    int seen;

    tbl[0]  = '{OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
    tbl[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[2]  = '{OP_ADC, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    tbl[3]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
    tbl[4]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    tbl[5]  = '{OP_SBB, 16'h0005, 16'h0002, 16'h0002, 1'b0, 1'b0};
    tbl[6]  = '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    tbl[7]  = '{OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0};
    tbl[8]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
    tbl[9]  = '{OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0};
    tbl[10] = '{OP_SHL, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0};
    tbl[11] = '{OP_SHR, 16'h0003, 16'h0000, 16'h0001, 1'b1, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_dst = 3'd0; cmd_src1 = 3'd0;
    cmd_src2 = 3'd0; cmd_wb = 1'b0; cmd_fl = 1'b0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'd0; dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
    ref_flags = 5'd0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_oe", 32'(alu_oe), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_carry", 32'(alu_carry), 32'd0);
    for (int a = 0; a < 8; a++) check_reg("rst_reg", 3'(a), 16'd0);

    // Table of single operations on R1,R2 -> R3 with writeback and flag update.
    for (int i = 0; i < 12; i++) begin
      do_load(3'd1, tbl[i].a);
      do_load(3'd2, tbl[i].b);
      run_cmd(tbl[i].op, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1, 0, d, f);
      check($sformatf("tbl%0d_data", i), 32'(d), 32'(tbl[i].exp_d));
      check($sformatf("tbl%0d_c", i), 32'(f[FL_C]), 32'(tbl[i].exp_c));
      check($sformatf("tbl%0d_z", i), 32'(f[FL_Z]), 32'(tbl[i].exp_z));
      check_reg($sformatf("tbl%0d_r3", i), 3'd3, tbl[i].exp_d);
    end

    // Carry chain: ADD sets C, ADC on zero operands sees it.
    do_load(3'd1, 16'hFFFF); do_load(3'd2, 16'h0001);
    do_load(3'd4, 16'h0000); do_load(3'd5, 16'h0000);
    run_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1, 0, d, f);
    check("chain_add_c", 32'(flags_q[FL_C]), 32'd1);
    run_cmd(OP_ADC, 3'd6, 3'd4, 3'd5, 1'b1, 1'b1, 0, d, f);
    check("chain_carry_in", 32'(ex_carry), 32'd1);
    check("chain_adc", 32'(d), 32'h0001);

    // Compare use: flags only, destination untouched.
    do_load(3'd1, 16'h0005); do_load(3'd2, 16'h0005); do_load(3'd7, 16'hABCD);
    run_cmd(OP_SUB, 3'd7, 3'd1, 3'd2, 1'b0, 1'b1, 0, d, f);
    check_reg("cmp_dst_kept", 3'd7, 16'hABCD);
    check("cmp_z", 32'(flags_q[FL_Z]), 32'd1);

    // Full aliasing: operands read before writeback.
    do_load(3'd5, 16'h1234);
    run_cmd(OP_ADD, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0, 0, d, f);
    check_reg("alias_r5", 3'd5, 16'h2468);

    // Backpressure for 5 cycles.
    run_cmd(OP_XOR, 3'd0, 3'd5, 3'd7, 1'b1, 1'b1, 5, d, f);

    // Load during EXEC to another register, load to dst during WB (WB wins).
    do_load(3'd1, 16'h0010); do_load(3'd2, 16'h0020); do_load(3'd3, 16'h5555);
    cmd_opcode = OP_ADD; cmd_dst = 3'd3; cmd_src1 = 3'd1; cmd_src2 = 3'd2;
    cmd_wb = 1'b1; cmd_fl = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    tick(); cmd_valid = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'h1234;
    tick();
    ld_addr = 3'd3; ld_data = 16'hBEEF;
    tick();
    ld_en = 1'b0;
    check("coll_rsp_valid", 32'(rsp_valid), 32'd1);
    check("coll_rsp_data", 32'(rsp_data), 32'h0030);
    tick();
    ref_regs[7] = 16'h1234; ref_regs[3] = 16'h0030;
    check_reg("coll_wb_wins", 3'd3, 16'h0030);
    check_reg("coll_ld_exec", 3'd7, 16'h1234);

    // Load has priority over a command offered in the same IDLE cycle.
    cmd_opcode = OP_ADD; cmd_dst = 3'd0; cmd_src1 = 3'd0; cmd_src2 = 3'd0;
    cmd_wb = 1'b1; cmd_fl = 1'b0; cmd_valid = 1'b1;
    ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'h0042;
    #1;
    check("ldprio_ready", 32'(cmd_ready), 32'd0);
    tick();
    ld_en = 1'b0; cmd_valid = 1'b0; ref_regs[4] = 16'h0042;
    #1;
    check("ldprio_idle", 32'(cmd_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (rsp_valid) seen++; end
    check("ldprio_no_rsp", 32'(seen), 32'd0);
    check_reg("ldprio_reg", 3'd4, 16'h0042);

    // Randomized commands against the reference model.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) do_load(3'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 2) == 0) do_load(3'($urandom_range(0, 7)), 16'($urandom));
      run_cmd(4'($urandom_range(0, 11)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), d, f);
      check_reg("rand_dbg", 3'(k % 8), ref_regs[k % 8]);
    end

    // Reset while in EXEC drops the command entirely.
    do_load(3'd1, 16'h0001); do_load(3'd2, 16'h0002);
    cmd_opcode = OP_ADD; cmd_dst = 3'd6; cmd_src1 = 3'd1; cmd_src2 = 3'd2;
    cmd_wb = 1'b1; cmd_fl = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check("abort_accept", 32'(cmd_ready), 32'd1);
    tick(); cmd_valid = 1'b0;
    tick();
    check("abort_in_exec", 32'(alu_oe), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
    ref_flags = 5'd0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin if (rsp_valid) seen++; tick(); end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check_reg("abort_dst", 3'd6, 16'd0);
    check("abort_flags", 32'(flags_q), 32'd0);
    check("abort_idle", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
